// File: rtl/cl_mem_scrubber_axi_pkg.sv
// rtl/cl_mem_scrubber_axi_pkg.sv - shared state type, pattern modes and burst helpers for the AXI scrubber
package cl_mem_scrubber_axi_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AW    = 3'd1,
      S_W     = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } scrb_state_e;

   localparam logic [1:0] PAT_ZERO = 2'd0;
   localparam logic [1:0] PAT_REPL = 2'd1;
   localparam logic [1:0] PAT_ADDR = 2'd2;

   function automatic int unsigned burst_bytes(int unsigned burst_len, int unsigned data_w);
      return burst_len * data_w / 8;
   endfunction

   function automatic logic [2:0] axi_size(int unsigned data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/cl_mem_scrubber_axi_if.sv
// rtl/cl_mem_scrubber_axi_if.sv - AXI4 write-only channel bundle between scrubber and memory slave
interface cl_mem_scrubber_axi_if #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 64,
   parameter int ID_W   = 16
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic                awvalid;
   logic                awready;
   logic [ID_W-1:0]     wid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awid, awaddr, awlen, awsize, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/cl_mem_scrubber_axi_tag_table.sv
// rtl/cl_mem_scrubber_axi_tag_table.sv - per-ID burst address table, written on AW handshake, read by bid
module cl_mem_scrubber_axi_tag_table #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64,
   parameter int ID_W   = 16,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [ADDR_W-1:0] i_wdata,
   input  logic [ID_W-1:0]   i_ridx,
   output logic [ADDR_W-1:0] o_rdata
);
   logic [ADDR_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_widx] <= i_wdata;
      end
   end

   // IDs we never issued read back as zero rather than aliasing onto a live entry
   assign o_rdata = ({1'b0, i_ridx} < (ID_W+1)'(DEPTH)) ? r_mem[i_ridx[IDX_W-1:0]] : '0;
endmodule

// File: rtl/cl_mem_scrubber_axi.sv
// rtl/cl_mem_scrubber_axi.sv - fills [start,end) with a pattern using AXI4 write bursts, MAX_OUTS in flight
module cl_mem_scrubber_axi
   import cl_mem_scrubber_axi_pkg::*;
#(
   parameter int DATA_W    = 512,
   parameter int ADDR_W    = 64,
   parameter int ID_W      = 16,
   parameter int BURST_LEN = 64,
   parameter int MAX_OUTS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic [1:0]        i_pattern_mode,
   input  logic [63:0]       i_pattern,
   output logic [2:0]        o_state,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_err_addr,
   cl_mem_scrubber_axi_if.master axi
);
   localparam int unsigned BB         = burst_bytes(BURST_LEN, DATA_W);
   localparam int          LANES      = DATA_W / 64;
   localparam int          BEAT_BYTES = DATA_W / 8;
   localparam int          BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int          SEQ_W      = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam int          OUTS_W     = $clog2(MAX_OUTS + 1);
   localparam logic [2:0]  AW_SIZE    = axi_size(DATA_W);

   scrb_state_e       r_state, w_state_nxt;
   logic              r_en_q, r_abort, r_err;
   logic [ADDR_W-1:0] r_addr, r_end, r_err_addr;
   logic [63:0]       r_pattern;
   logic [1:0]        r_mode;
   logic [BEAT_W-1:0] r_beat;
   logic [SEQ_W-1:0]  r_seq, r_wid;
   logic [OUTS_W-1:0] r_outs;

   logic              w_rise, w_start, w_empty, w_abort, w_awvalid, w_aw_hs, w_w_hs, w_b_hs, w_last;
   logic [ADDR_W-1:0] w_addr_nxt, w_beat_addr, w_tag_rdata;
   logic [DATA_W-1:0] w_wdata;

   assign w_rise     = i_enable & ~r_en_q;
   assign w_start    = (r_state == S_IDLE) & w_rise;
   assign w_empty    = i_end_addr <= i_start_addr;
   assign w_abort    = r_abort | ~i_enable;
   // awvalid depends only on registered state, so once raised it holds until the handshake
   assign w_awvalid  = (r_state == S_AW) && (r_outs < OUTS_W'(MAX_OUTS));
   assign w_aw_hs    = w_awvalid & axi.awready;
   assign w_last     = r_beat == BEAT_W'(BURST_LEN - 1);
   assign w_w_hs     = (r_state == S_W) & axi.wready;
   assign w_b_hs     = axi.bvalid & axi.bready;
   assign w_addr_nxt = r_addr + ADDR_W'(BB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_rise) w_state_nxt = w_empty ? S_DONE : S_AW;
         S_AW: begin
            if (w_aw_hs)                    w_state_nxt = S_W;
            else if (w_abort && !w_awvalid) w_state_nxt = S_DRAIN;
         end
         S_W: begin
            if (w_w_hs && w_last)
               w_state_nxt = (w_addr_nxt == r_end || w_abort) ? S_DRAIN : S_AW;
         end
         S_DRAIN: if (r_outs == '0) w_state_nxt = w_abort ? S_IDLE : S_DONE;
         S_DONE:  if (!i_enable) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_q     <= 1'b0;
         r_abort    <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_end      <= '0;
         r_err_addr <= '0;
         r_pattern  <= '0;
         r_mode     <= PAT_ZERO;
         r_beat     <= '0;
         r_seq      <= '0;
         r_wid      <= '0;
         r_outs     <= '0;
      end else begin
         r_en_q <= i_enable;
         if (r_state == S_IDLE) r_abort <= 1'b0;
         else if (!i_enable)    r_abort <= 1'b1;
         if (w_start) begin
            r_end     <= i_end_addr;
            r_mode    <= i_pattern_mode;
            r_pattern <= i_pattern;
            r_addr    <= w_empty ? i_end_addr : i_start_addr;
            r_beat    <= '0;
            r_seq     <= '0;
         end
         if (w_aw_hs) begin
            r_wid <= r_seq;
            r_seq <= (r_seq == SEQ_W'(MAX_OUTS - 1)) ? '0 : r_seq + 1'b1;
         end
         if (w_w_hs) begin
            r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_last) r_addr <= w_addr_nxt;
         end
         r_outs <= r_outs + OUTS_W'(w_aw_hs) - OUTS_W'(w_b_hs);
         // only the first failing burst is kept until the next run starts
         if (w_start) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
         end else if (w_b_hs && axi.bresp != 2'b00 && !r_err) begin
            r_err      <= 1'b1;
            r_err_addr <= w_tag_rdata;
         end
      end
   end

   assign w_beat_addr = r_addr + ADDR_W'(r_beat) * ADDR_W'(BEAT_BYTES);

   always_comb begin
      w_wdata = '0;
      for (int k = 0; k < LANES; k++) begin
         case (r_mode)
            PAT_ZERO: w_wdata[k*64 +: 64] = '0;
            PAT_REPL: w_wdata[k*64 +: 64] = r_pattern;
            PAT_ADDR: w_wdata[k*64 +: 64] = 64'(w_beat_addr + ADDR_W'(8 * k));
            default:  w_wdata[k*64 +: 64] = '0;
         endcase
      end
   end

   cl_mem_scrubber_axi_tag_table #(
      .DEPTH (MAX_OUTS),
      .ADDR_W(ADDR_W),
      .ID_W  (ID_W),
      .IDX_W (SEQ_W)
   ) u_tag_table (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_aw_hs),
      .i_widx (r_seq),
      .i_wdata(r_addr),
      .i_ridx (axi.bid),
      .o_rdata(w_tag_rdata)
   );

   assign axi.awid    = ID_W'(r_seq);
   assign axi.awaddr  = r_addr;
   assign axi.awlen   = 8'(BURST_LEN - 1);
   assign axi.awsize  = AW_SIZE;
   assign axi.awvalid = w_awvalid;
   assign axi.wid     = ID_W'(r_wid);
   assign axi.wdata   = w_wdata;
   assign axi.wstrb   = '1;
   assign axi.wlast   = w_last;
   assign axi.wvalid  = r_state == S_W;
   assign axi.bready  = 1'b1;

   assign o_state    = r_state;
   assign o_addr     = r_addr;
   assign o_done     = r_state == S_DONE;
   assign o_err      = r_err;
   assign o_err_addr = r_err_addr;
endmodule

// File: tb/tb_cl_mem_scrubber_axi.sv
// tb/tb_cl_mem_scrubber_axi.sv - scoreboard bench: directed runs, AXI slave model, expected-beat queues
module tb_cl_mem_scrubber_axi;
   typedef struct {logic [63:0] addr; logic [15:0] id;} aw_t;
   typedef struct {logic [511:0] data; logic last;} w_t;
   typedef struct {logic [15:0] id; logic [1:0] resp; int due;} b_t;

   logic        clk = 1'b0;
   logic        rst_n, enable;
   logic [63:0] start_addr, end_addr, pattern;
   logic [1:0]  mode;
   logic [2:0]  o_state;
   logic [63:0] o_addr, o_err_addr;
   logic        o_done, o_err;

   cl_mem_scrubber_axi_if #(.DATA_W(512), .ADDR_W(64), .ID_W(16)) axi ();

   cl_mem_scrubber_axi #(
      .DATA_W(512), .ADDR_W(64), .ID_W(16), .BURST_LEN(64), .MAX_OUTS(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_start_addr(start_addr), .i_end_addr(end_addr),
      .i_pattern_mode(mode), .i_pattern(pattern), .o_state(o_state), .o_addr(o_addr), .o_done(o_done),
      .o_err(o_err), .o_err_addr(o_err_addr), .axi(axi.master)
   );

   always #5 clk = ~clk;

   aw_t  exp_aw[$];
   w_t   exp_w[$];
   b_t   bq[$];
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, outs = 0, max_outs = 0;
   int   w_cnt = 0, b_cnt = 0, aw_cnt = 0;
   int   b_delay = 2;
   bit   rnd_ready = 0;
   logic [63:0]  err_a = '1, err_b = '1;
   logic [15:0]  cur_wid = '0;
   logic [511:0] first_data = '0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_expect(input logic [63:0] s, input int nb, input logic [1:0] m, input logic [63:0] p);
      for (int b = 0; b < nb; b++) begin
         exp_aw.push_back('{addr: s + 64'(b * 4096), id: 16'(b % 4)});
         for (int t = 0; t < 64; t++) begin
            logic [511:0] d;
            logic [63:0]  ba;
            ba = s + 64'(b * 4096 + t * 64);
            for (int k = 0; k < 8; k++)
               d[k*64 +: 64] = (m == 2'd1) ? p : (m == 2'd2) ? ba + 64'(8 * k) : 64'h0;
            exp_w.push_back('{data: d, last: (t == 63)});
         end
      end
   endtask

   task automatic start_run(input logic [63:0] s, input logic [63:0] e, input logic [1:0] m, input logic [63:0] p);
      @(posedge clk); #1;
      w_cnt = 0; b_cnt = 0; aw_cnt = 0; max_outs = 0;
      start_addr = s; end_addr = e; mode = m; pattern = p; enable = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string name);
      int n;
      n = 0;
      while (o_state !== st && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, o_state, st);
   endtask

   task automatic end_run(input string name);
      chk({name, "_queues_empty"}, exp_aw.size() + exp_w.size(), 0);
      enable = 1'b0;
      @(posedge clk); #1;
      chk({name, "_idle"}, o_state, 3'd0);
      chk({name, "_done_low"}, o_done, 1'b0);
   endtask

   // AXI slave: ready generation and in-order delayed B responses
   initial begin
      b_t b;
      axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
      forever begin
         @(posedge clk); #2;
         cyc++;
         axi.awready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
         axi.wready  = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
         if (!rst_n) begin
            axi.bvalid = 1'b0;
            bq.delete();
         end else begin
            axi.bvalid = 1'b0;
            if (bq.size() > 0 && bq[0].due <= cyc) begin
               b = bq.pop_front();
               axi.bvalid = 1'b1; axi.bid = b.id; axi.bresp = b.resp;
            end
         end
      end
   end

   // monitor: handshakes are visible at the negedge preceding the edge that takes them
   initial begin
      aw_t e;
      w_t  w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (axi.awvalid && axi.awready) begin
               aw_cnt++;
               if (exp_aw.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL aw_unexpected: got awaddr %0h expected no burst", axi.awaddr);
               end else begin
                  e = exp_aw.pop_front();
                  chk("awaddr", axi.awaddr, e.addr);
                  chk("awid", axi.awid, e.id);
                  chk("awlen", axi.awlen, 8'd63);
                  chk("awsize", axi.awsize, 3'd6);
                  chk("outstanding_below_max", outs < 4, 1'b1);
               end
               cur_wid = axi.awid;
               outs++;
               if (outs > max_outs) max_outs = outs;
               bq.push_back('{id: axi.awid,
                              resp: (axi.awaddr == err_a || axi.awaddr == err_b) ? 2'b10 : 2'b00,
                              due: cyc + b_delay});
            end
            if (axi.wvalid && axi.wready) begin
               w_cnt++;
               if (w_cnt == 1) first_data = axi.wdata;
               if (exp_w.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL w_unexpected: got beat %0d expected no beat", w_cnt);
               end else begin
                  w = exp_w.pop_front();
                  chk("wdata", axi.wdata, w.data);
                  chk("wlast", axi.wlast, w.last);
                  chk("wstrb", axi.wstrb, {64{1'b1}});
                  chk("wid", axi.wid, cur_wid);
               end
            end
            if (axi.bvalid) begin
               chk("bready", axi.bready, 1'b1);
               outs--;
               b_cnt++;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; enable = 1'b0; start_addr = '0; end_addr = '0; mode = '0; pattern = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", o_state, 3'd0);
      chk("rst_addr", o_addr, 64'h0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_err_addr", o_err_addr, 64'h0);
      chk("rst_awvalid", axi.awvalid, 1'b0);
      chk("rst_wvalid", axi.wvalid, 1'b0);
      chk("rst_bready", axi.bready, 1'b1);
      rst_n = 1'b1;

      // 1: zero fill of 64 KiB
      push_expect(64'h0, 16, 2'd0, 64'h0);
      start_run(64'h0, 64'h10000, 2'd0, 64'h0);
      wait_state(3'd4, 5000, "t1_done_state");
      chk("t1_done", o_done, 1'b1);
      chk("t1_err", o_err, 1'b0);
      chk("t1_addr_end", o_addr, 64'h10000);
      chk("t1_beats", w_cnt, 1024);
      chk("t1_bresps", b_cnt, 16);
      end_run("t1");

      // 2: address-as-data, one burst
      push_expect(64'h1000, 1, 2'd2, 64'h0);
      start_run(64'h1000, 64'h2000, 2'd2, 64'h0);
      wait_state(3'd4, 1000, "t2_done_state");
      chk("t2_beat0_lane1", first_data[127:64], 64'h1008);
      chk("t2_beat0_lane7", first_data[511:448], 64'h1038);
      end_run("t2");

      // 3: random backpressure, slow B
      rnd_ready = 1; b_delay = 50;
      push_expect(64'h0, 16, 2'd1, 64'hDEAD_BEEF_0123_4567);
      start_run(64'h0, 64'h10000, 2'd1, 64'hDEAD_BEEF_0123_4567);
      wait_state(3'd4, 20000, "t3_done_state");
      chk("t3_max_outstanding", max_outs <= 4, 1'b1);
      chk("t3_bresps", b_cnt, 16);
      end_run("t3");
      rnd_ready = 0; b_delay = 2;

      // 4: SLVERR on 3rd and 5th bursts
      err_a = 64'h8000; err_b = 64'hA000;
      push_expect(64'h6000, 5, 2'd0, 64'h0);
      start_run(64'h6000, 64'hB000, 2'd0, 64'h0);
      wait_state(3'd4, 2000, "t4_done_state");
      chk("t4_err", o_err, 1'b1);
      chk("t4_err_addr", o_err_addr, 64'h8000);
      end_run("t4");
      err_a = '1; err_b = '1;

      // 5: abort during beat 20 of burst 2
      push_expect(64'h0, 3, 2'd1, 64'h5A5A_0000_FFFF_A5A5);
      start_run(64'h0, 64'h10000, 2'd1, 64'h5A5A_0000_FFFF_A5A5);
      n = 0;
      while (w_cnt < 148 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_reached_beat", w_cnt >= 148, 1'b1);
      chk("t5_err_cleared", o_err, 1'b0);
      enable = 1'b0;
      wait_state(3'd0, 2000, "t5_idle_state");
      chk("t5_done", o_done, 1'b0);
      chk("t5_beats", w_cnt, 192);
      chk("t5_bresps", b_cnt, 3);
      chk("t5_queues_empty", exp_aw.size() + exp_w.size(), 0);

      // reset in the middle of a W burst
      push_expect(64'h0, 16, 2'd0, 64'h0);
      start_run(64'h0, 64'h10000, 2'd0, 64'h0);
      n = 0;
      while (w_cnt < 10 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      rst_n = 1'b0; enable = 1'b0;
      #1;
      chk("mid_rst_state", o_state, 3'd0);
      chk("mid_rst_addr", o_addr, 64'h0);
      chk("mid_rst_done", o_done, 1'b0);
      chk("mid_rst_wvalid", axi.wvalid, 1'b0);
      chk("mid_rst_awvalid", axi.awvalid, 1'b0);
      exp_aw.delete(); exp_w.delete(); outs = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 6: empty range completes in one cycle with no traffic
      start_run(64'h4000, 64'h4000, 2'd0, 64'h0);
      @(posedge clk); #1;
      chk("t6_state_done", o_state, 3'd4);
      chk("t6_done", o_done, 1'b1);
      chk("t6_addr", o_addr, 64'h4000);
      repeat (5) @(posedge clk);
      #1;
      chk("t6_no_aw", aw_cnt, 0);
      end_run("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
